cfu_mac_sequencer: RTL and testbench
====================================

Name: cfu_mac_sequencer

Overview:
- CFU that runs a whole int8 dot-product in one command instead of one word pair per command.
- Walks two word-aligned vectors in RAM through its Wishbone-classic read master and runs a 4-lane SIMD multiply-accumulate on each matrix/filter word pair.
- Returns the 32-bit accumulator to the CPU over the standard cmd/rsp handshake.
- Sits between the CPU's CFU port and the cfu_ram bus.

Parameters:
- LEN_W, 16, width of the word-pair count register.
- TIMEOUT_CYC, 255, max cycles to wait for ack/err on one read; 0 disables the watchdog.
- DEFAULT_OFFSET, 128, reset value of the signed 9-bit input offset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_payload_function_id  in  10  [2:0]=op, [3]=clear-before-run, [9:4] ignored.
- cmd_payload_inputs_0  in  32  operand 0.
- cmd_payload_inputs_1  in  32  operand 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_payload_outputs_0  out  32  response data.
- cfu_ram_adr  out  30  word address.
- cfu_ram_dat_mosi  out  32  tied 0.
- cfu_ram_sel  out  4  tied 4'b1111.
- cfu_ram_cyc  out  1  bus cycle.
- cfu_ram_stb  out  1  strobe.
- cfu_ram_we  out  1  tied 0.
- cfu_ram_cti  out  3  tied 0.
- cfu_ram_bte  out  2  tied 0.
- cfu_ram_dat_miso  in  32  read data.
- cfu_ram_ack  in  1  read acknowledge.
- cfu_ram_err  in  1  bus error.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rsp_valid=0; rsp_payload=0.
  - acc=0, len=0, offset=DEFAULT_OFFSET, sticky err/timeout flags=0.
  - cyc=stb=0 immediately; an in-flight RUN is abandoned with no response.
- States: IDLE, REQ_A, REQ_B, MAC, RESP.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready; operands are latched on acceptance.
- Ops, in IDLE, accept -> RESP next cycle (1-cycle latency) unless noted:
  - 0 RUN: ptr_a=inputs_0[31:2], ptr_b=inputs_1[31:2], cnt=len; if function_id[3], acc cleared first. If len==0 -> RESP with acc, else -> REQ_A.
  - 1 SET_LEN: len=inputs_0[LEN_W-1:0]; rsp=0.
  - 2 SET_OFFSET: offset=inputs_0[8:0], signed; rsp=0.
  - 3 READ_ACC: rsp=acc.
  - 4 CLEAR_ACC: acc=0; rsp=0.
  - 5 READ_STATUS: rsp={30'b0, timeout, err}; both flags cleared on the same accept.
  - 6, 7: rsp=0, no side effects.
- REQ_A: cyc=stb=1, adr=ptr_a.
  - On ack: latch dat_miso into word_a, -> REQ_B.
- REQ_B: cyc=stb=1, adr=ptr_b.
  - On ack: latch into word_b, -> MAC.
- cyc/stb/adr are combinational from state and pointers. cyc/stb stay high across REQ_A->REQ_B (legal classic address change). cyc/stb are 0 in MAC, RESP and IDLE.
- MAC:
  - acc += sum of 4 lanes, lane i = (sext(word_a byte i) + offset) * sext(word_b byte i).
  - Lane products are 17-bit signed; the sum is sign-extended to 32 bits; acc wraps mod 2^32.
  - ptr_a += 1, ptr_b += 1 (word units; 30-bit wrap); cnt -= 1.
  - cnt==0 after decrement -> RESP with rsp=acc; else -> REQ_A.
- err in REQ_A/REQ_B: set sticky err, drop cyc/stb, -> RESP with the current acc (the pair is not accumulated).
- Simultaneous ack and err: err wins.
- Watchdog:
  - Cycle counter reset on entry to each REQ state.
  - Reaching TIMEOUT_CYC without ack/err: set sticky timeout, -> RESP with acc.
- RESP:
  - rsp_valid=1; payload stable until rsp_ready.
  - rsp_ready -> IDLE the next cycle, rsp_valid=0. A back-to-back command is accepted no earlier than the cycle after that.

Decomposition:
- Package cfu_mac_pkg:
  - state enum.
  - op codes: OP_RUN, OP_SET_LEN, OP_SET_OFFSET, OP_READ_ACC, OP_CLEAR_ACC, OP_READ_STATUS.
  - status bit indices.
- Sub-module simd_mac4: combinational 4-lane offset-multiply-sum (word_a, word_b, offset -> 32-bit signed sum), reusable by other CFUs.

Test Plan:
- SET_LEN 1, SET_OFFSET 128, RUN clear, A=0x00000000, B=0x01010101, ack after 2 cycles -> rsp=512; adr sequence A>>2, then B>>2.
- SET_LEN 3, RUN clear with words A=0x7F7F7F7F, B=0x02020202 at every address -> each pair 4*(255*2)=2040; rsp=6120; adr increments by 1 per pair.
- LEN=0, RUN with clear=0 after acc=6120 -> rsp=6120 one cycle after accept; cyc never asserted.
- LEN=4, err on the 2nd pair's REQ_B -> rsp = first-pair sum only; READ_STATUS=1, then READ_STATUS=0.
- TIMEOUT_CYC=8, no ack -> cyc drops after 8 cycles; rsp=acc; READ_STATUS=2.
- reset_n low during REQ_B -> cyc/stb low immediately, rsp_valid=0; READ_ACC=0 and offset back to 128 after reset.

Source files
------------

// File: rtl/cfu_mac_pkg.sv
// Shared types and constants for the MAC sequencer CFU.
package cfu_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_A,
        ST_REQ_B,
        ST_MAC,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_RUN         = 3'd0,
        OP_SET_LEN     = 3'd1,
        OP_SET_OFFSET  = 3'd2,
        OP_READ_ACC    = 3'd3,
        OP_CLEAR_ACC   = 3'd4,
        OP_READ_STATUS = 3'd5
    } op_e;

    // Bit positions inside the READ_STATUS response word
    localparam int unsigned STAT_ERR     = 0;
    localparam int unsigned STAT_TIMEOUT = 1;

    // function_id bit requesting an accumulator clear before RUN
    localparam int unsigned FID_CLEAR_BIT = 3;

endpackage

// File: rtl/cfu_mac_sequencer_simd_mac4.sv
// Combinational 4-lane int8 offset-multiply-sum:
// sum = sum_i (sext(a_i) + offset) * sext(b_i), sign-extended to 32 bits.
module simd_mac4 (
    input  logic        [31:0] word_a,
    input  logic        [31:0] word_b,
    input  logic signed [8:0]  offset,
    output logic signed [31:0] sum
);

    logic signed [31:0] a_ext;
    logic signed [31:0] b_ext;

    // Sum the four lane products in 32-bit signed arithmetic
    always_comb begin
        sum   = '0;
        a_ext = '0;
        b_ext = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            a_ext = 32'(signed'(word_a[8*i +: 8])) + 32'(offset);
            b_ext = 32'(signed'(word_b[8*i +: 8]));
            sum   = sum + a_ext * b_ext;
        end
    end

endmodule

// File: rtl/cfu_mac_sequencer.sv
// CFU that runs a full int8 dot product over two word vectors in RAM via a
// Wishbone-classic read master and returns the 32-bit accumulator.
module cfu_mac_sequencer
    import cfu_mac_pkg::*;
#(
    parameter int unsigned       LEN_W          = 16,
    parameter int unsigned       TIMEOUT_CYC    = 255,
    parameter logic signed [8:0] DEFAULT_OFFSET = 9'sd128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [29:0] cfu_ram_adr,
    output logic [31:0] cfu_ram_dat_mosi,
    output logic [3:0]  cfu_ram_sel,
    output logic        cfu_ram_cyc,
    output logic        cfu_ram_stb,
    output logic        cfu_ram_we,
    output logic [2:0]  cfu_ram_cti,
    output logic [1:0]  cfu_ram_bte,
    input  logic [31:0] cfu_ram_dat_miso,
    input  logic        cfu_ram_ack,
    input  logic        cfu_ram_err
);

    localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    state_e            state, state_next;
    logic [31:0]       acc, acc_next;
    logic [31:0]       rsp_data, rsp_next;
    logic [31:0]       word_a, word_a_next;
    logic [31:0]       word_b, word_b_next;
    logic [LEN_W-1:0]  len, len_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic signed [8:0] offset, offset_next;
    logic              err_flag, err_next;
    logic              to_flag, to_next;
    logic [29:0]       ptr_a, ptr_a_next;
    logic [29:0]       ptr_b, ptr_b_next;
    logic [WD_W-1:0]   wd, wd_next;

    logic signed [31:0] mac_sum;
    logic [31:0]        acc_sum;
    logic [31:0]        acc_base;
    logic [31:0]        status;
    logic               in_req;
    logic               wd_expired;
    op_e                op;
    logic               unused_bits;

    simd_mac4 u_mac (
        .word_a (word_a),
        .word_b (word_b),
        .offset (offset),
        .sum    (mac_sum)
    );

    assign op          = op_e'(cmd_payload_function_id[2:0]);
    assign in_req      = (state == ST_REQ_A) || (state == ST_REQ_B);
    assign wd_expired  = (TIMEOUT_CYC != 0) && (wd == WD_W'(WD_LAST));
    assign acc_sum     = acc + $unsigned(mac_sum);
    assign acc_base    = cmd_payload_function_id[FID_CLEAR_BIT] ? '0 : acc;
    assign unused_bits = ^{cmd_payload_function_id[9:4], cmd_payload_inputs_1[1:0],
                           cmd_payload_inputs_0[1:0]};

    assign cmd_ready             = (state == ST_IDLE);
    assign rsp_valid             = (state == ST_RESP);
    assign rsp_payload_outputs_0 = rsp_data;

    assign cfu_ram_cyc      = in_req;
    assign cfu_ram_stb      = in_req;
    assign cfu_ram_adr      = (state == ST_REQ_B) ? ptr_b : ptr_a;
    assign cfu_ram_dat_mosi = '0;
    assign cfu_ram_sel      = '1;
    assign cfu_ram_we       = 1'b0;
    assign cfu_ram_cti      = '0;
    assign cfu_ram_bte      = '0;

    // Pack sticky flags into the status response word
    always_comb begin
        status               = '0;
        status[STAT_ERR]     = err_flag;
        status[STAT_TIMEOUT] = to_flag;
    end

    // Next-state and datapath updates
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        rsp_next    = rsp_data;
        word_a_next = word_a;
        word_b_next = word_b;
        len_next    = len;
        cnt_next    = cnt;
        offset_next = offset;
        err_next    = err_flag;
        to_next     = to_flag;
        ptr_a_next  = ptr_a;
        ptr_b_next  = ptr_b;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_RESP;
                    rsp_next   = '0;
                    case (op)
                        OP_RUN: begin
                            ptr_a_next = cmd_payload_inputs_0[31:2];
                            ptr_b_next = cmd_payload_inputs_1[31:2];
                            cnt_next   = len;
                            acc_next   = acc_base;
                            if (len == '0) begin
                                rsp_next = acc_base;
                            end else begin
                                state_next = ST_REQ_A;
                            end
                        end
                        OP_SET_LEN:     len_next    = cmd_payload_inputs_0[LEN_W-1:0];
                        OP_SET_OFFSET:  offset_next = cmd_payload_inputs_0[8:0];
                        OP_READ_ACC:    rsp_next    = acc;
                        OP_CLEAR_ACC:   acc_next    = '0;
                        OP_READ_STATUS: begin
                            rsp_next = status;
                            err_next = 1'b0;
                            to_next  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_REQ_A, ST_REQ_B: begin
                // err has priority over ack; the watchdog only fires when neither arrived
                if (cfu_ram_err) begin
                    err_next   = 1'b1;
                    rsp_next   = acc;
                    state_next = ST_RESP;
                end else if (cfu_ram_ack) begin
                    if (state == ST_REQ_A) begin
                        word_a_next = cfu_ram_dat_miso;
                        state_next  = ST_REQ_B;
                    end else begin
                        word_b_next = cfu_ram_dat_miso;
                        state_next  = ST_MAC;
                    end
                end else if (wd_expired) begin
                    to_next    = 1'b1;
                    rsp_next   = acc;
                    state_next = ST_RESP;
                end
            end
            ST_MAC: begin
                acc_next   = acc_sum;
                ptr_a_next = ptr_a + 30'd1;
                ptr_b_next = ptr_b + 30'd1;
                cnt_next   = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    rsp_next   = acc_sum;
                    state_next = ST_RESP;
                end else begin
                    state_next = ST_REQ_A;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Watchdog restarts on every entry into a request state
        wd_next = '0;
        if (in_req && (state_next == state)) begin
            wd_next = wd + 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            rsp_data <= '0;
            word_a   <= '0;
            word_b   <= '0;
            len      <= '0;
            cnt      <= '0;
            offset   <= DEFAULT_OFFSET;
            err_flag <= 1'b0;
            to_flag  <= 1'b0;
            ptr_a    <= '0;
            ptr_b    <= '0;
            wd       <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            rsp_data <= rsp_next;
            word_a   <= word_a_next;
            word_b   <= word_b_next;
            len      <= len_next;
            cnt      <= cnt_next;
            offset   <= offset_next;
            err_flag <= err_next;
            to_flag  <= to_next;
            ptr_a    <= ptr_a_next;
            ptr_b    <= ptr_b_next;
            wd       <= wd_next;
        end
    end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Self-checking bench for cfu_mac_sequencer: table vectors, directed corner
// sequences and randomized runs against a dot-product reference model.
module tb_cfu_mac_sequencer;

    localparam int TMO = 8;
    localparam int LIMIT = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  fid = '0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_payload;
    logic [29:0] adr;
    logic [31:0] mosi;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] miso = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    cfu_mac_sequencer #(
        .LEN_W          (16),
        .TIMEOUT_CYC    (TMO),
        .DEFAULT_OFFSET (9'sd128)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload),
        .cfu_ram_adr             (adr),
        .cfu_ram_dat_mosi        (mosi),
        .cfu_ram_sel             (sel),
        .cfu_ram_cyc             (cyc),
        .cfu_ram_stb             (stb),
        .cfu_ram_we              (we),
        .cfu_ram_cti             (cti),
        .cfu_ram_bte             (bte),
        .cfu_ram_dat_miso        (miso),
        .cfu_ram_ack             (ack),
        .cfu_ram_err             (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RAM model and slave configuration (config written only by the main process)
    logic [31:0] mem [logic [29:0]];
    int          delay = 0;
    int          err_idx = -1;
    int          stall_from = -1;
    // Slave bookkeeping (written only by the slave process)
    int          reads_done = 0;
    int          cyc_cycles = 0;
    int          wait_cnt = 0;
    logic [29:0] adr_log[$];

    // Reference model state
    logic [31:0] m_acc = '0;
    int          m_len = 0;
    int          m_off = 128;
    logic [29:0] exp_log[$];

    typedef struct {
        logic [9:0]  fid;
        logic [31:0] in0;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[8];

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] pair_sum(input logic [31:0] a, input logic [31:0] b, input int off);
        int s;
        logic signed [7:0] x, y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            s += (int'(x) + off) * int'(y);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wishbone classic slave: ack/err after 'delay' idle cycles, one-cycle pulse
    initial begin
        forever begin
            @(negedge clk);
            if (cyc) cyc_cycles++;
            if (!reset_n || ack || err) begin
                ack = 1'b0;
                err = 1'b0;
                wait_cnt = 0;
            end else if (cyc && stb) begin
                if (stall_from >= 0 && reads_done >= stall_from) begin
                    wait_cnt = 0;
                end else if (wait_cnt >= delay) begin
                    if (reads_done == err_idx) begin
                        err = 1'b1;
                    end else begin
                        ack = 1'b1;
                        miso = mem_rd(adr);
                        adr_log.push_back(adr);
                    end
                    reads_done++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Issue one command, wait for its response and complete the handshake
    task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int n;
        @(negedge clk);
        fid = f; in0 = a; in1 = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            r = 'x;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < LIMIT);
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            r = 'x;
            return;
        end
        r = rsp_payload;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic set_len(input int n);
        logic [31:0] r;
        int lat;
        do_cmd(10'd1, 32'(n), 32'h0, r, lat);
        check("set_len_rsp", r, 32'h0);
        m_len = n;
    endtask

    task automatic set_off(input logic [31:0] v);
        logic [31:0] r;
        int lat;
        logic signed [8:0] o9;
        do_cmd(10'd2, v, 32'h0, r, lat);
        check("set_off_rsp", r, 32'h0);
        o9 = v[8:0];
        m_off = int'(o9);
    endtask

    task automatic model_run(input logic [29:0] pa, input logic [29:0] pb, input logic clr,
                             output logic [31:0] r);
        if (clr) m_acc = '0;
        exp_log.delete();
        for (int k = 0; k < m_len; k++) begin
            exp_log.push_back(pa + 30'(k));
            exp_log.push_back(pb + 30'(k));
            m_acc += pair_sum(mem_rd(pa + 30'(k)), mem_rd(pb + 30'(k)), m_off);
        end
        r = m_acc;
    endtask

    task automatic check_log(input string name, input int start);
        int bad;
        bad = 0;
        if (adr_log.size() - start != exp_log.size()) bad = 1;
        else
            for (int i = 0; i < exp_log.size(); i++)
                if (adr_log[start + i] !== exp_log[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] r, e;
        int          lat, st, c0;
        logic [29:0] pa, pb;
        logic        clr;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready_valid", {30'b0, cmd_ready, rsp_valid}, 32'h2);
        check("reset_bus_idle", {30'b0, cyc, stb}, 32'h0);
        check("reset_payload", rsp_payload, 32'h0);
        check("tieoffs", {mosi[15:0], sel, we, cti, bte, 6'b0}, {16'h0, 4'hF, 12'h0});
        reset_n = 1'b1;
        @(negedge clk);

        // Single pair, ack after 2 idle cycles: (0+128)*1*4 = 512
        set_len(1);
        set_off(32'd128);
        mem[30'h40] = 32'h00000000;
        mem[30'h80] = 32'h01010101;
        delay = 2;
        st = adr_log.size();
        do_cmd(10'h008, 32'h100, 32'h200, r, lat);
        model_run(30'h40, 30'h80, 1'b1, e);
        check("run1_rsp", r, 32'd512);
        check("run1_model", e, 32'd512);
        check_log("run1_adr", st);

        // Three pairs, each (127+128)*2*4 = 2040
        set_len(3);
        for (int k = 0; k < 4; k++) begin
            mem[30'h400 + 30'(k)] = 32'h7F7F7F7F;
            mem[30'h800 + 30'(k)] = 32'h02020202;
        end
        delay = 0;
        st = adr_log.size();
        do_cmd(10'h008, 32'h1000, 32'h2000, r, lat);
        model_run(30'h400, 30'h800, 1'b1, e);
        check("run3_rsp", r, 32'd6120);
        check_log("run3_adr", st);

        // len==0: immediate response, no bus activity
        set_len(0);
        c0 = cyc_cycles;
        do_cmd(10'h000, 32'h1000, 32'h2000, r, lat);
        check("len0_rsp", r, 32'd6120);
        check("len0_latency", 32'(lat), 32'd1);
        check("len0_no_cyc", 32'(cyc_cycles - c0), 32'd0);

        // Table of register ops, starting from acc=6120
        vt[0] = '{10'h003, 32'h0,        32'd6120};
        vt[1] = '{10'h3F3, 32'hFFFFFFFF, 32'd6120};
        vt[2] = '{10'h006, 32'hFFFFFFFF, 32'd0};
        vt[3] = '{10'h007, 32'h12345678, 32'd0};
        vt[4] = '{10'h005, 32'h0,        32'd0};
        vt[5] = '{10'h004, 32'h0,        32'd0};
        vt[6] = '{10'h003, 32'h0,        32'd0};
        vt[7] = '{10'h001, 32'hABCD0001, 32'd0};
        for (int i = 0; i < 8; i++) begin
            do_cmd(vt[i].fid, vt[i].in0, 32'h0, r, lat);
            check($sformatf("vec%0d_rsp", i), r, vt[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
        end
        m_acc = '0;
        m_len = 1;
        // len register took inputs_0[15:0]=1: one pair of 2040 on top of acc 0
        st = adr_log.size();
        do_cmd(10'h000, 32'h1000, 32'h2000, r, lat);
        check("table_len_run", r, 32'd2040);

        // Bus error on the second pair's B read
        set_len(4);
        err_idx = reads_done + 3;
        st = adr_log.size();
        do_cmd(10'h008, 32'h1000, 32'h2000, r, lat);
        err_idx = -1;
        check("err_rsp", r, 32'd2040);
        check("err_reads", 32'(adr_log.size() - st), 32'd3);
        do_cmd(10'h005, 32'h0, 32'h0, r, lat);
        check("status_err", r, 32'd1);
        do_cmd(10'h005, 32'h0, 32'h0, r, lat);
        check("status_err_cleared", r, 32'd0);
        m_acc = 32'd2040;

        // Watchdog: no ack at all
        set_len(2);
        stall_from = reads_done;
        c0 = cyc_cycles;
        do_cmd(10'h000, 32'h1000, 32'h2000, r, lat);
        stall_from = -1;
        check("tmo_rsp", r, 32'd2040);
        check("tmo_cyc_cycles", 32'(cyc_cycles - c0), 32'(TMO));
        do_cmd(10'h005, 32'h0, 32'h0, r, lat);
        check("status_tmo", r, 32'd2);
        do_cmd(10'h005, 32'h0, 32'h0, r, lat);
        check("status_tmo_cleared", r, 32'd0);

        // Randomized runs against the reference model
        for (int it = 0; it < 25; it++) begin
            set_off($urandom);
            set_len($urandom_range(1, 4));
            pa = 30'($urandom);
            pb = 30'($urandom);
            if (it == 3) pa = 30'h3FFFFFFE;
            for (int k = 0; k < m_len; k++) begin
                mem[pa + 30'(k)] = $urandom;
                mem[pb + 30'(k)] = $urandom;
            end
            delay = $urandom_range(0, 3);
            clr = 1'($urandom);
            st = adr_log.size();
            do_cmd({6'($urandom), clr, 3'd0}, {pa, 2'($urandom)}, {pb, 2'($urandom)}, r, lat);
            model_run(pa, pb, clr, e);
            check($sformatf("rand%0d_rsp", it), r, e);
            check_log($sformatf("rand%0d_adr", it), st);
            do_cmd(10'h003, 32'h0, 32'h0, r, lat);
            check($sformatf("rand%0d_acc", it), r, m_acc);
        end

        // Reset asserted while waiting in REQ_B
        set_off(32'h1FF);
        set_len(2);
        delay = 0;
        stall_from = reads_done + 1;
        @(negedge clk);
        fid = 10'h008; in0 = 32'h3000; in1 = 32'h3100; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cyc && adr == 30'hC40) && n < 50);
        check("reqb_reached", {1'b0, cyc, adr}, {2'b01, 30'hC40});
        reset_n = 1'b0;
        #1;
        check("reset_drops_bus", {29'b0, cyc, stb, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        stall_from = -1;
        reset_n = 1'b1;
        m_acc = '0; m_len = 0; m_off = 128;
        do_cmd(10'h003, 32'h0, 32'h0, r, lat);
        check("post_reset_acc", r, 32'd0);
        do_cmd(10'h005, 32'h0, 32'h0, r, lat);
        check("post_reset_status", r, 32'd0);
        set_len(1);
        do_cmd(10'h008, 32'h100, 32'h200, r, lat);
        check("post_reset_offset", r, 32'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
